// File: rtl/music_pkg.sv
// Shared constants and types for the ROM-driven music player: note periods in 50 MHz clock
// cycles, the rest code, default song length and the player state encoding.
package music_pkg;

  typedef logic [32:0] note_t;

  // Full tone periods in clk cycles (50 MHz / f)
  localparam note_t D5  = 33'd255102;
  localparam note_t D6  = 33'd227273;
  localparam note_t D7  = 33'd202429;
  localparam note_t M1  = 33'd190840;
  localparam note_t M2  = 33'd170068;
  localparam note_t M3  = 33'd151515;
  localparam note_t M4  = 33'd143266;
  localparam note_t M5  = 33'd127551;
  localparam note_t M6  = 33'd113636;
  localparam note_t M7  = 33'd101215;
  localparam note_t H1  = 33'd95602;
  localparam note_t H2  = 33'd85179;
  localparam note_t H3  = 33'd75873;
  localparam note_t H4  = 33'd71633;
  localparam note_t H5  = 33'd63776;
  localparam note_t H6  = 33'd56818;
  localparam note_t H7  = 33'd50607;
  localparam note_t HH1 = 33'd47801;
  localparam note_t HH2 = 33'd42553;

  localparam int unsigned REST_CODE = 2500;
  localparam int unsigned SONG_LEN  = 384;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StPlay,
    StDone
  } player_state_e;

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: counts the note period while playing and drives the buzzer
// high for the first half of each period unless the note is a rest.
module tone_gen #(
  parameter int unsigned REST_CODE = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play_en_i,
  input  logic [32:0] note_i,
  output logic        beep_o
);
  import music_pkg::*;

  // play_en_i / note_i are next-cycle values so the registered beep lines up with PLAY.
  note_t tone_cnt_q, tone_cnt_d;
  logic  play_q;
  logic  beep_q, beep_d;
  logic  silent;

  always_comb begin
    silent     = (note_i == note_t'(REST_CODE)) || (note_i < note_t'(2));
    tone_cnt_d = '0;
    if (play_en_i && play_q && (tone_cnt_q < note_i - note_t'(1))) begin
      tone_cnt_d = tone_cnt_q + note_t'(1);
    end
    beep_d = play_en_i && !silent && (tone_cnt_d < (note_i >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      play_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      play_q     <= play_en_i;
      beep_q     <= beep_d;
    end
  end

  assign beep_o = beep_q;

endmodule

// File: rtl/music_player.sv
// ROM-sequenced buzzer player: FETCH/LATCH each note word, play it for BEAT_CYCLES, then advance.
// Define MUSIC_LOOP_EN to restart from address 0 after the last entry instead of stopping.
module music_player #(
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned SONG_LEN    = 384,
  parameter int unsigned REST_CODE   = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic [8:0]  address,
  input  logic [32:0] note_in,
  output logic        beep,
  output logic        busy,
  output logic        done
);
  import music_pkg::*;

  localparam int unsigned BeatW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BEAT_CYCLES - 1);
  localparam logic [8:0] AddrLast = 9'(SONG_LEN - 1);

  player_state_e    state_q, state_d;
  logic [8:0]       addr_q, addr_d;
  note_t            note_q, note_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StFetch;
          addr_d  = '0;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        note_d  = note_in;
        beat_d  = '0;
        state_d = StPlay;
      end
      StPlay: begin
        beat_d = beat_q + BeatW'(1);
        if (beat_q == BeatLast) begin
          beat_d = '0;
          if (addr_q < AddrLast) begin
            addr_d  = addr_q + 9'd1;
            state_d = StFetch;
          end else begin
            addr_d = '0;
            done_d = 1'b1;
`ifdef MUSIC_LOOP_EN
            state_d = StFetch;
`else
            state_d = StDone;
`endif
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort takes priority over everything, including a same-cycle start or song end.
    if (stop && (state_q != StIdle)) begin
      state_d = StIdle;
      addr_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      note_q  <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
    end
  end

  tone_gen #(
    .REST_CODE(REST_CODE)
  ) u_tone_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .play_en_i(state_d == StPlay),
    .note_i   (note_d),
    .beep_o   (beep)
  );

  assign address = addr_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with a 4-entry stub ROM and 16-cycle beats.
module tb_music_player;

  localparam int unsigned BeatCycles = 16;
  localparam int unsigned SongLen    = 4;

  typedef struct {
    logic [32:0] note;
    logic [8:0]  addr;
    logic [15:0] pat;   // expected beep per PLAY cycle, MSB = first cycle
  } entry_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [8:0]  address;
  logic [32:0] note_in;
  logic        beep, busy, done;

  logic [32:0] rom [SongLen];
  entry_t      song [SongLen];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  // Registered stub ROM: data valid one cycle after address
  always @(posedge clk) note_in <= rom[address[1:0]];

  music_player #(
    .BEAT_CYCLES(BeatCycles),
    .SONG_LEN   (SongLen),
    .REST_CODE  (2500)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .address(address),
    .note_in(note_in),
    .beep   (beep),
    .busy   (busy),
    .done   (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int e_busy, input int e_done, input int e_beep,
                       input int e_addr);
    logic [11:0] act, exp;
    act = {busy, done, beep, address};
    exp = {1'(e_busy), 1'(e_done), 1'(e_beep), 9'(e_addr)};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b beep=%b addr=%0d, want busy=%b done=%b beep=%b addr=%0d",
               name, busy, done, beep, address, exp[11], exp[10], exp[9], exp[8:0]);
    end
  endtask

  // Starts in the FETCH cycle of entry i, ends in the cycle after its last PLAY cycle.
  task automatic play_entry(input string tag, input int i, input int pat_idx, input int done_f);
    check($sformatf("%s_e%0d_fetch", tag, i), 1, done_f, 0, song[i].addr);
    tick();
    check($sformatf("%s_e%0d_latch", tag, i), 1, 0, 0, song[i].addr);
    tick();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_e%0d_play%0d", tag, i, k), 1, 0, song[pat_idx].pat[15-k], song[i].addr);
      tick();
    end
  endtask

  initial begin
    song[0] = '{note: 33'd10,   addr: 9'd0, pat: 16'b1111_1000_0011_1110};
    song[1] = '{note: 33'd2500, addr: 9'd1, pat: 16'b0000_0000_0000_0000};
    song[2] = '{note: 33'd8,    addr: 9'd2, pat: 16'b1111_0000_1111_0000};
    song[3] = '{note: 33'd0,    addr: 9'd3, pat: 16'b0000_0000_0000_0000};
    for (int i = 0; i < int'(SongLen); i++) rom[i] = song[i].note;

    #2 rst_n = 1'b0;
    #10;
    check("reset_hold", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 0, 0, 0, 0);

    // Full song, table-driven
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(SongLen); i++) play_entry("song", i, i, 0);
`ifdef MUSIC_LOOP_EN
    play_entry("loop", 0, 0, 1);
    check("loop_e1_fetch", 1, 0, 0, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("loop_stop", 0, 0, 0, 0);
`else
    check("done_pulse", 0, 1, 0, 0);
    start = 1'b1;  // ignored in DONE
    tick();
    start = 1'b0;
    check("idle_after_done", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("done_once_%0d", k), 0, 0, 0, 0);
    end
`endif

    // Stop in the 7th PLAY cycle of entry 2
    start = 1'b1;
    tick();
    start = 1'b0;
    play_entry("t4", 0, 0, 0);
    play_entry("t4", 1, 1, 0);
    repeat (8) tick();
    check("t4_play7", 1, 0, 0, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_stopped", 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t4_no_done_%0d", k), 0, 0, 0, 0);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("t4_start_stop", 0, 0, 0, 0);
    tick();
    check("t4_still_idle", 0, 0, 0, 0);

    // Start while busy ignored, then asynchronous reset mid-PLAY
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_fetch", 1, 0, 0, 0);
    repeat (4) tick();
    check("t5_play3", 1, 0, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_play4_ignored", 1, 0, 1, 0);
    repeat (13) tick();
    check("t5_next_fetch", 1, 0, 0, 1);
    repeat (20) tick();
    check("t5_e2_play1", 1, 0, 1, 2);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_reset", 0, 0, 0, 0);
    tick();
    check("t5_reset_hold", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("t5_wait_start0", 0, 0, 0, 0);
    tick();
    check("t5_wait_start1", 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart", 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
